ovl_win_unchange_stim: RTL and testbench

- Protocol-compliant stimulus generator, the driving end of the windowed "value unchanged" checker interface.
- Produces start_event/end_event window framing and a test_expr bus that is held stable inside each window and changes outside it.
- Supports optional single-shot violation injection to exercise the checker's fire path.
- Used in OVL self-check benches, instantiated beside the win_unchange checker with outputs wired directly to its inputs.

---
 rtl/ovl_win_unchange_stim_if.sv | 25 ++
 rtl/ovl_win_unchange_stim.sv | 71 +++++++
 tb/tb_ovl_win_unchange_stim.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ovl_win_unchange_stim_if.sv
// ovl_win_unchange_stim_if: control inputs and window outputs of the win_unchange stimulus generator
interface ovl_win_unchange_stim_if #(
    parameter int width        = 8,
    parameter int cnt_width    = 8,
    parameter int wcount_width = 16
);
    logic                    enable;
    logic                    inject_err;
    logic [cnt_width-1:0]    win_len;
    logic [cnt_width-1:0]    gap_len;
    logic                    start_event;
    logic                    end_event;
    logic                    window_o;
    logic                    err_injected;
    logic [width-1:0]        test_expr;
    logic [wcount_width-1:0] win_count;
    modport master (
        input  enable, inject_err, win_len, gap_len,
        output start_event, end_event, window_o, err_injected, test_expr, win_count
    );
    modport slave (
        output enable, inject_err, win_len, gap_len,
        input  start_event, end_event, window_o, err_injected, test_expr, win_count
    );
endinterface

// File: rtl/ovl_win_unchange_stim.sv
// ovl_win_unchange_stim: frames start/end windows and holds test_expr stable inside them
module ovl_win_unchange_stim #(
    parameter int width        = 8,
    parameter int cnt_width    = 8,
    parameter int wcount_width = 16
) (
    input logic                      clk,
    input logic                      reset_n,
    ovl_win_unchange_stim_if.master  bus
);
    typedef enum logic [1:0] {IDLE, START, OPEN, GAP} state_t;
    state_t               state, nxt;
    logic [cnt_width-1:0] wcnt, wnxt, gcnt, gnxt, len, lnxt, glen;
    logic                 inj;
    assign inj = state == START && bus.inject_err;
    always_comb begin
        nxt  = state;
        wnxt = wcnt;
        gnxt = gcnt;
        lnxt = len;
        case (state)
            IDLE:  nxt = bus.enable ? START : IDLE;
            START: begin
                nxt  = OPEN;
                wnxt = cnt_width'(1);
                lnxt = bus.win_len == '0 ? cnt_width'(1) : bus.win_len;
            end
            OPEN: begin
                if (wcnt == len) begin
                    nxt  = bus.gap_len != '0 ? GAP : bus.enable ? START : IDLE;
                    gnxt = cnt_width'(1);
                end else
                    wnxt = wcnt + cnt_width'(1);
            end
            default: begin
                if (gcnt == glen)
                    nxt = bus.enable ? START : IDLE;
                else
                    gnxt = gcnt + cnt_width'(1);
            end
        endcase
    end
    // outputs are registered from the next-state decode so they line up with state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            wcnt             <= '0;
            gcnt             <= '0;
            len              <= '0;
            glen             <= '0;
            bus.start_event  <= 1'b0;
            bus.end_event    <= 1'b0;
            bus.window_o     <= 1'b0;
            bus.err_injected <= 1'b0;
            bus.test_expr    <= '0;
            bus.win_count    <= '0;
        end else begin
            state            <= nxt;
            wcnt             <= wnxt;
            gcnt             <= gnxt;
            len              <= lnxt;
            glen             <= state == OPEN && wcnt == len ? bus.gap_len : glen;
            bus.start_event  <= nxt == START;
            bus.end_event    <= nxt == OPEN && wnxt == lnxt;
            bus.window_o     <= nxt == OPEN;
            bus.err_injected <= inj;
            bus.test_expr    <= nxt == OPEN ? bus.test_expr ^ width'(inj) : bus.test_expr + width'(1);
            bus.win_count    <= bus.win_count + wcount_width'(bus.end_event);
        end
    end
endmodule

// File: tb/tb_ovl_win_unchange_stim.sv
// tb_ovl_win_unchange_stim: schedule-queue reference model plus directed literal checks
module tb_ovl_win_unchange_stim;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ovl_win_unchange_stim_if #(8, 8, 16) bus();
    ovl_win_unchange_stim #(.width(8), .cnt_width(8), .wcount_width(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // one record per output cycle; dec marks a cycle after which enable picks START or IDLE
    typedef struct packed {logic se, ee, win, err, dec;} rec_t;
    localparam rec_t IDLE_R  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam rec_t START_R = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rec_t       cur, nx, q[$];
    logic [7:0] tv;
    logic [15:0] wc;
    bit         mvalid = 0;
    int         wl;

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            cur = IDLE_R;
            tv = 8'h00;
            wc = 16'h0;
            mvalid = 1;
        end else if (mvalid) begin
            wc = wc + 16'(cur.ee);
            if (cur.se) begin
                wl = bus.win_len == 0 ? 1 : int'(bus.win_len);
                for (int i = 0; i < wl; i++)
                    q.push_back('{1'b0, i == wl - 1, 1'b1, i == 0 && bus.inject_err, 1'b0});
            end
            if (cur.ee)
                for (int i = 0; i < int'(bus.gap_len); i++)
                    q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, i == int'(bus.gap_len) - 1});
            if (q.size() != 0)
                nx = q.pop_front();
            else
                nx = bus.enable ? START_R : IDLE_R;
            tv = nx.win ? tv ^ {7'b0, nx.err} : tv + 8'h01;
            cur = nx;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            chk("start_event", 32'(bus.start_event), 32'(cur.se));
            chk("end_event", 32'(bus.end_event), 32'(cur.ee));
            chk("window_o", 32'(bus.window_o), 32'(cur.win));
            chk("err_injected", 32'(bus.err_injected), 32'(cur.err));
            chk("test_expr", 32'(bus.test_expr), 32'(tv));
            chk("win_count", 32'(bus.win_count), 32'(wc));
            chk("se_ee_exclusive", 32'(bus.start_event & bus.end_event), 32'd0);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_window", 32'(bus.window_o), 0);
        chk("rst_end", 32'(bus.end_event), 0);
        chk("rst_start", 32'(bus.start_event), 0);
        chk("rst_test", 32'(bus.test_expr), 0);
        chk("rst_count", 32'(bus.win_count), 0);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.win_len = 8'd3;
        bus.gap_len = 8'd2;
        bus.inject_err = 1'b0;
        @(negedge clk);
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin chk("t1_start_c1", 32'(bus.start_event), 1); chk("t1_test_c1", 32'(bus.test_expr), 1); end
            if (k >= 2 && k <= 4) chk("t1_window", 32'(bus.window_o), 1);
            if (k == 3) chk("t1_end_c3", 32'(bus.end_event), 0);
            if (k == 4) begin chk("t1_end_c4", 32'(bus.end_event), 1); chk("t1_test_c4", 32'(bus.test_expr), 1); end
            if (k == 5) begin
                chk("t1_window_c5", 32'(bus.window_o), 0);
                chk("t1_test_c5", 32'(bus.test_expr), 2);
                chk("t1_count_c5", 32'(bus.win_count), 1);
            end
            if (k == 6) chk("t1_start_c6", 32'(bus.start_event), 0);
            if (k == 7) chk("t1_start_c7", 32'(bus.start_event), 1);
        end
        bus.enable = 1'b0;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (k == 255) chk("wrap_ff", 32'(bus.test_expr), 32'hff);
            if (k == 256) chk("wrap_00", 32'(bus.test_expr), 32'h00);
        end
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 15) begin bus.enable = 1'b1; bus.inject_err = 1'b1; bus.win_len = 8'd2; bus.gap_len = 8'd0; end
            if (k == 16) begin chk("inj_start", 32'(bus.start_event), 1); chk("inj_test_start", 32'(bus.test_expr), 32'h10); end
            if (k == 17) begin
                bus.inject_err = 1'b0;
                bus.enable = 1'b0;
                chk("inj_test_first", 32'(bus.test_expr), 32'h11);
                chk("inj_pulse", 32'(bus.err_injected), 1);
            end
            if (k == 18) begin
                chk("inj_test_end", 32'(bus.test_expr), 32'h11);
                chk("inj_pulse_off", 32'(bus.err_injected), 0);
                chk("inj_end", 32'(bus.end_event), 1);
            end
            if (k == 19) begin chk("inj_after", 32'(bus.test_expr), 32'h12); chk("inj_no_start", 32'(bus.start_event), 0); end
        end
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            reset_n = $urandom_range(0, 299) != 0;
            bus.enable = $urandom_range(0, 9) != 0;
            bus.win_len = 8'($urandom_range(0, 5));
            bus.gap_len = 8'($urandom_range(0, 3));
            bus.inject_err = $urandom_range(0, 3) == 0;
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
